// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared constants and operation encodings for the shift pipeline.
// Revision : 1.0  initial release
// ============================================================================
package shift_pkg;

  localparam int WORD_W = 16;

  // Operation select encodings driven on the op port
  typedef enum logic [1:0] {
    SHOP_SLL  = 2'b00,
    SHOP_SRL  = 2'b01,
    SHOP_SRA  = 2'b10,
    SHOP_ROTL = 2'b11
  } shop_e;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift16_core.sv
`default_nettype none
// ============================================================================
// Module   : shift16_core
// Brief    : Combinational 16-bit shifter with carry-out and zero flag.
//            Define SHIFT_EXEC_ROTATE_EN to enable rotate-left on op 11;
//            otherwise op 11 behaves exactly as a logical left shift.
// Revision : 1.0  initial release
// ============================================================================
module shift16_core
  import shift_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] a,
  input  logic [3:0]        n,
  output logic [WORD_W-1:0] r,
  output logic              zero,
  output logic              carry
);

  // n-1 selects the last bit leaving on right shifts; its complement (15-(n-1)
  // = 16-n) selects the last bit leaving on left shifts.
  logic [3:0] w_nm1;
  assign w_nm1 = n - 4'd1;

`ifdef SHIFT_EXEC_ROTATE_EN
  logic [WORD_W-1:0] w_rot;
  assign w_rot = (a << n) | (a >> (5'd16 - {1'b0, n}));
`endif

  // Result and carry select; a zero shift amount passes a through with no carry
  always_comb begin
    r     = a;
    carry = 1'b0;
    if (n != 4'd0) begin
      case (op)
        SHOP_SRL: begin
          r     = a >> n;
          carry = a[w_nm1];
        end
        SHOP_SRA: begin
          r     = WORD_W'($signed(a) >>> n);
          carry = a[w_nm1];
        end
`ifdef SHIFT_EXEC_ROTATE_EN
        SHOP_ROTL: begin
          r     = w_rot;
          carry = w_rot[0];
        end
`endif
        default: begin
          r     = a << n;
          carry = a[~w_nm1];
        end
      endcase
    end
  end

  assign zero = (r == '0);

endmodule : shift16_core
`default_nettype wire

// File: rtl/shift_exec.sv
`default_nettype none
// ============================================================================
// Module   : shift_exec
// Brief    : Two-stage valid/ready shift execution pipeline. S1 registers the
//            operand bundle, S2 registers result/zero/carry. Build option
//            SHIFT_EXEC_ROTATE_EN enables rotate-left for op 11.
// Revision : 1.0  initial release
// ============================================================================
module shift_exec
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] r,
  output logic              zero,
  output logic              carry
);

  logic              r_s1_valid;
  logic [1:0]        r_s1_op;
  logic [WORD_W-1:0] r_s1_a;
  logic [3:0]        r_s1_n;

  logic              w_s2_adv;
  logic [WORD_W-1:0] w_r;
  logic              w_zero;
  logic              w_carry;

  logic [WORD_W-5:0] w_b_unused;
  assign w_b_unused = b[WORD_W-1:4];

  // S2 can take new data when empty or when its result leaves this cycle
  assign w_s2_adv = !out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  shift16_core u_core (
    .op    (r_s1_op),
    .a     (r_s1_a),
    .n     (r_s1_n),
    .r     (w_r),
    .zero  (w_zero),
    .carry (w_carry)
  );

  // S1: capture an accepted bundle; empties when its contents move to S2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 2'b00;
      r_s1_a     <= '0;
      r_s1_n     <= 4'd0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= op;
        r_s1_a  <= a;
        r_s1_n  <= b[3:0];
      end
    end
  end

  // S2: register the computed result whenever the output slot frees up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      r         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
    end else if (w_s2_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r     <= w_r;
        zero  <= w_zero;
        carry <= w_carry;
      end
    end
  end

endmodule : shift_exec
`default_nettype wire

// File: doc/shift_exec.md
SHIFT_EXEC -- requirements
Module: shift_exec

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, upstream operand bundle valid.
REQ-004 SHALL have port in_ready, output, 1, the block can accept the bundle this cycle.
REQ-005 SHALL have port op, input, 2, operation select: 00 sll, 01 srl, 10 sra, 11 rotl.
REQ-006 SHALL have port a, input, 16, value to shift.
REQ-007 SHALL have port b, input, 16, shift amount; only b[3:0] is used.
REQ-008 SHALL have port out_valid, output, 1, result bundle valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the result this cycle.
REQ-010 SHALL have port r, output, 16, shifted result.
REQ-011 SHALL have port zero, output, 1, high when r == 16'h0000.
REQ-012 SHALL have port carry, output, 1, last bit shifted out.

Function
REQ-013 SHALL be a two-register pipeline: S1 holds op/a/b[3:0]; S2 holds r/zero/carry.
REQ-014 SHALL accept a transfer on a rising edge where in_valid && in_ready.
REQ-015 SHALL accept a transfer out on a rising edge where out_valid && out_ready.
REQ-016 SHALL drive in_ready = !s1_valid || s2_adv, where s2_adv = !out_valid || out_ready; in_ready has no combinational dependence on in_valid.
REQ-017 SHALL present a result accepted at edge k with out_valid high after edge k+1 (latency 2 edges) when out_ready stays high.
REQ-018 SHALL sustain one transfer per cycle with out_ready held high.
REQ-019 SHALL hold S1 and S2 contents stable while out_valid && !out_ready; no bundle lost, duplicated or reordered.
REQ-020 SHALL load S1 and move S1 to S2 on the same edge when both advance (simultaneous accept and drain).
REQ-021 SHALL compute from S1: sll r=a<<n; srl r=a>>n, zero fill; sra r=a>>n, sign fill; rotl r=(a<<n)|(a>>(16-n)); n=b[3:0].
REQ-022 SHALL set carry: sll a[16-n]; srl/sra a[n-1]; rotl r[0]; carry=0 whenever n=0, for every op.
REQ-023 SHALL compute zero from the final 16-bit r.
REQ-024 SHALL ignore op, a and b when in_valid is low or in_ready is low.

Reset
REQ-025 SHALL clear s1_valid, out_valid, r, zero and carry to 0 immediately on reset assertion, regardless of clk.
REQ-026 SHALL discard any in-flight bundle when reset asserts mid-operation.
REQ-027 SHALL drive in_ready=1 during reset and on the first cycle after release.

Configuration
REQ-028 SHALL, with SHIFT_EXEC_ROTATE_EN defined, implement op 11 as rotl per REQ-021/022.
REQ-029 SHALL, without SHIFT_EXEC_ROTATE_EN, execute op 11 exactly as sll, including carry.

Structure
REQ-030 SHALL place the op encodings (SHOP_SLL/SRL/SRA/ROTL) and the WORD_W=16 constant in shared package shift_pkg.
REQ-031 SHALL isolate the combinational shift/carry/zero logic in sub-module shift16_core; shift_exec holds only pipeline registers and handshake.

Verification
REQ-032 SHALL cover reset: assert reset mid-stream -> out_valid=0, r=0, carry=0 at once; in_ready=1 after release.
REQ-033 SHALL cover sll: a=16'h0001, b=4, op=00 -> r=16'h0010, carry=0, zero=0, out_valid two edges after accept.
REQ-034 SHALL cover srl/sra: srl a=16'h0001 b=1 -> r=0, zero=1, carry=1; sra a=16'h8000 b=15 -> r=16'hFFFF, carry=0.
REQ-035 SHALL cover backpressure: out_ready=0, three back-to-back inputs -> two accepted, in_ready=0 thereafter; results emerge in order once out_ready=1.
REQ-036 SHALL cover the macro: op=11, a=16'h8001, b=1 -> r=16'h0003, carry=1 with SHIFT_EXEC_ROTATE_EN; r=16'h0002, carry=1 without.
REQ-037 SHALL cover n=0: a=16'hA5A5, b=16'h0010 (b[3:0]=0) -> r=16'hA5A5, carry=0 for all ops.
